fft32_out_serializer: RTL and testbench



---
 rtl/fft32_out_serializer.sv | 155 +++++++++++++++
 tb/tb_fft32_out_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fft32_out_serializer.sv
// Output serializer for the 32-point FFT: captures a parallel frame and streams bins 0..31 over valid/ready.
// Define FFT32_SER_PINGPONG_EN for two banks (gapless streaming); default is a single bank with IDLE/STREAM.
module fft32_out_serializer #(
  parameter int IN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*IN_W-1:0]     in_r,
  input  logic [32*IN_W-1:0]     in_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IN_W-1:0] out_r,
  output logic signed [IN_W-1:0] out_i,
  output logic [4:0]             out_idx,
  output logic                   out_last
);
  localparam int N = 32;
`ifdef FFT32_SER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic signed [IN_W-1:0] cap_r [N];
  logic signed [IN_W-1:0] cap_i [N];
  logic signed [IN_W-1:0] bank_r_q [NB][N];
  logic signed [IN_W-1:0] bank_i_q [NB][N];
  logic [NB-1:0]          cap_en;
  logic                   capture;
  logic                   in_ready_q, in_ready_d;
  logic [4:0]             rd_idx_q, rd_idx_d;
  logic signed [IN_W-1:0] rd_r, rd_i;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign cap_r[gi] = in_r[gi*IN_W +: IN_W];
      assign cap_i[gi] = in_i[gi*IN_W +: IN_W];
    end
    // Bank contents need no reset: they are only visible while marked valid.
    for (gi = 0; gi < NB; gi++) begin : g_bank
      always_ff @(posedge clk) begin
        if (cap_en[gi]) begin
          for (int k = 0; k < N; k++) begin
            bank_r_q[gi][k] <= cap_r[k];
            bank_i_q[gi][k] <= cap_i[k];
          end
        end
      end
    end
  endgenerate

  assign capture  = in_valid && in_ready_q;
  assign in_ready = in_ready_q;

`ifdef FFT32_SER_PINGPONG_EN
  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;

  assign out_valid = full_q[rd_bank_q];
  assign cap_en    = {capture && wr_bank_q, capture && !wr_bank_q};
  assign rd_r      = bank_r_q[rd_bank_q][rd_idx_q];
  assign rd_i      = bank_i_q[rd_bank_q][rd_idx_q];

  // A capture needs an empty write bank and a release needs a full read bank,
  // so both may act on the same edge without touching the same flag.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    if (capture) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (out_valid && out_ready) begin
      if (rd_idx_q == 5'd31) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = 5'd0;
      end else begin
        rd_idx_d = rd_idx_q + 5'd1;
      end
    end
    in_ready_d = !full_d[wr_bank_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= 5'd0;
      in_ready_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0] state_q, state_d;

  assign out_valid = (state_q == STREAM);
  assign cap_en    = capture;
  assign rd_r      = bank_r_q[0][rd_idx_q];
  assign rd_i      = bank_i_q[0][rd_idx_q];

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d  = STREAM;
          rd_idx_d = 5'd0;
        end
      end
      default: begin
        if (out_ready) begin
          if (rd_idx_q == 5'd31) state_d = IDLE;
          else rd_idx_d = rd_idx_q + 5'd1;
        end
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_idx_q   <= 5'd0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      in_ready_q <= in_ready_d;
    end
  end
`endif

  // Outputs are forced to zero whenever no beat is presented.
  assign out_r    = out_valid ? rd_r : '0;
  assign out_i    = out_valid ? rd_i : '0;
  assign out_idx  = out_valid ? rd_idx_q : 5'd0;
  assign out_last = out_valid && (rd_idx_q == 5'd31);
endmodule

// File: tb/tb_fft32_out_serializer.sv
// Directed bench for fft32_out_serializer: table-driven frames plus reset, overlap and mid-frame reset sequences.
module tb_fft32_out_serializer;
  localparam int IN_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [32*IN_W-1:0] in_r;
  logic [32*IN_W-1:0] in_i;
  logic              out_valid;
  logic              out_ready;
  logic [IN_W-1:0]   out_r;
  logic [IN_W-1:0]   out_i;
  logic [4:0]        out_idx;
  logic              out_last;

  int n_cmp = 0;
  int n_bad = 0;

  fft32_out_serializer #(.IN_W(IN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    int sa0;
    int sl0;
    int sa1;
    int sl1;
    int exp_cyc;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [7:0] pat_r(int p, int k);
    case (p)
      0:       return 8'(k);
      1:       return 8'h80;
      default: return 8'(k * 7 - 100);
    endcase
  endfunction

  function automatic logic [7:0] pat_i(int p, int k);
    case (p)
      0:       return 8'(-k);
      1:       return 8'h7F;
      default: return 8'(k ^ 32'h5A);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int p);
    for (int k = 0; k < 32; k++) begin
      in_r[k*IN_W +: IN_W] = pat_r(p, k);
      in_i[k*IN_W +: IN_W] = pat_i(p, k);
    end
  endtask

  task automatic chk_beat(input string nm, input int p, input int b);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_idx"},   32'(out_idx),   32'(b));
    chk({nm, "_r"},     32'(out_r),     32'(pat_r(p, b)));
    chk({nm, "_i"},     32'(out_i),     32'(pat_i(p, b)));
    chk({nm, "_last"},  32'(out_last),  32'(b == 31));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_r"},     32'(out_r),     32'd0);
    chk({nm, "_i"},     32'(out_i),     32'd0);
    chk({nm, "_idx"},   32'(out_idx),   32'd0);
    chk({nm, "_last"},  32'(out_last),  32'd0);
  endtask

  // Capture one frame from IDLE and stream it with the given stall windows.
  task automatic run_frame(input int p, input int sa0, input int sl0,
                           input int sa1, input int sl1, input int exp_cyc);
    int b = 0;
    int cyc = 0;
    int s0 = 0;
    int s1 = 0;
    logic rdy;
    chk("pre_in_ready", 32'(in_ready), 32'd1);
    load(p);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (b < 32 && cyc < 200) begin
      rdy = 1'b1;
      if (b == sa0 && s0 < sl0) begin rdy = 1'b0; s0++; end
      else if (b == sa1 && s1 < sl1) begin rdy = 1'b0; s1++; end
      out_ready = rdy;
      chk_beat("beat", p, b);
      if (rdy) b++;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk("frame_cycles", 32'(cyc), 32'(exp_cyc));
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    $display("frame pat=%0d stalls=%0d@%0d,%0d@%0d cycles=%0d", p, sl0, sa0, sl1, sa1, cyc);
  endtask

  initial begin
    int n;
    int bin0_s;
    int cap_s;
    int s;

    vecs[0] = '{pat: 0, sa0: -1, sl0: 0, sa1: -1, sl1: 0, exp_cyc: 32};
    vecs[1] = '{pat: 0, sa0: 5,  sl0: 3, sa1: 31, sl1: 1, exp_cyc: 36};
    vecs[2] = '{pat: 1, sa0: -1, sl0: 0, sa1: -1, sl1: 0, exp_cyc: 32};
    vecs[3] = '{pat: 2, sa0: 0,  sl0: 2, sa1: 17, sl1: 1, exp_cyc: 35};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_r = '0; in_i = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk_zero("rst");
    end
    rst = 1'b0;
    chk("rst_after_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("rst_released_in_ready", 32'(in_ready), 32'd1);
    chk_zero("idle");
    $display("reset sequence done");

    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].pat, vecs[v].sa0, vecs[v].sl0, vecs[v].sa1, vecs[v].sl1, vecs[v].exp_cyc);

    // Overlap: frame B presented continuously while frame A streams.
    load(0);
    in_valid = 1'b1;
    tick();
    load(2);
    n = 0; bin0_s = -1; cap_s = -1;
    for (s = 0; s < 80 && n < 64; s++) begin
      if (out_valid) begin
        if (n == 32) bin0_s = s;
        chk_beat("ovl", (n < 32) ? 0 : 2, n % 32);
        n++;
      end
      if (in_valid && in_ready && cap_s < 0) cap_s = s;
      tick();
      if (cap_s >= 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("ovl_beats", 32'(n), 32'd64);
`ifdef FFT32_SER_PINGPONG_EN
    chk("ovl_cap_sample", 32'(cap_s), 32'd0);
    chk("ovl_b_bin0", 32'(bin0_s), 32'd32);
`else
    chk("ovl_cap_sample", 32'(cap_s), 32'd32);
    chk("ovl_b_bin0", 32'(bin0_s), 32'd33);
`endif
    chk("ovl_post_valid", 32'(out_valid), 32'd0);
    $display("overlap capture_sample=%0d b_bin0_sample=%0d beats=%0d", cap_s, bin0_s, n);

    // Reset while bin 12 is on the outputs.
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    load(2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !(out_valid && out_idx == 5'd12); c++) tick();
    chk("mid_reached_12", 32'(out_idx), 32'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("mid_rst");
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    chk_zero("mid_idle");
    $display("mid-frame reset done");
    run_frame(0, -1, 0, -1, 0, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
